// File: rtl/out_port_pkg.sv
// Shared constants and sizing helpers for the output-port buffer and its bench.
package out_port_pkg;
  localparam int OUTPORT_DATA_W = 32;
  localparam int OUTPORT_DEPTH  = 4;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/out_port_buffer_if.sv
// Producer/consumer signals of the output-port buffer; slave = buffer side, master = CPU/device side.
interface out_port_buffer_if
  import out_port_pkg::*;
#(
  parameter int DATA_W = OUTPORT_DATA_W,
  parameter int DEPTH  = OUTPORT_DEPTH
);
  localparam int CNT_W = cnt_w(DEPTH);

  logic              OutPortin;
  logic [DATA_W-1:0] BusMuxOut;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport slave (
    input  OutPortin, BusMuxOut, out_ready,
    output out_data, out_valid, full, empty, count, overflow
  );

  modport master (
    output OutPortin, BusMuxOut, out_ready,
    input  out_data, out_valid, full, empty, count, overflow
  );
endinterface

// File: rtl/out_port_mem.sv
// DEPTH x DATA_W register array, one synchronous write port and one async read port; no reset on storage.
module out_port_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/out_port_buffer.sv
// Output-port FIFO: OutPortin words appear on out_data one edge after capture; never stalls the CPU, drops+flags when full.
// OUTPORT_MIRROR_EN adds OutPortData, a legacy register loaded on every OutPortin cycle.
module out_port_buffer
  import out_port_pkg::*;
#(
  parameter int DATA_W = OUTPORT_DATA_W,
  parameter int DEPTH  = OUTPORT_DEPTH
) (
  input  logic clock,
  input  logic clear,
  out_port_buffer_if.slave bus
`ifdef OUTPORT_MIRROR_EN
  ,
  output logic [DATA_W-1:0] OutPortData
`endif
);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_rdata;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && bus.out_ready;
  // A pop frees the head slot this edge, so a write at full is still accepted.
  assign w_push  = bus.OutPortin && (!w_full || w_pop);

  out_port_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .i_clk   (clock),
    .i_we    (w_push && clear),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.BusMuxOut),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      if (bus.OutPortin && !w_push) r_overflow <= 1'b1;
    end
  end

  assign bus.out_data  = w_empty ? '0 : w_rdata;
  assign bus.out_valid = !w_empty;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;

`ifdef OUTPORT_MIRROR_EN
  logic [DATA_W-1:0] r_mirror;

  always_ff @(posedge clock) begin
    if (!clear)             r_mirror <= '0;
    else if (bus.OutPortin) r_mirror <= bus.BusMuxOut;
  end

  assign OutPortData = r_mirror;
`endif
endmodule
